pool_window_buffer: RTL and testbench

Streaming window generator directly upstream of the Max pooling kernel. It accepts one DEPTH-bit pixel per handshake in raster order and buffers Y-1 image lines plus an X×Y shift window. At every stride-aligned position it emits a flattened X×Y window whose width and packing match the Max `Input` port, so `out_window` connects to Max with no glue logic.

---
 rtl/pool_window_buffer_pkg.sv | 17 +
 rtl/pool_window_buffer_line_delay.sv | 23 ++
 rtl/pool_window_buffer.sv | 115 +++++++++++
 tb/tb_pool_window_buffer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_window_buffer_pkg.sv
// Shared defaults and element packing for the pooling window path.
// DEPTH/X/Y defaults match the Max kernel so out_window connects without glue.
package pool_window_buffer_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_X      = 3;
  localparam int DEF_Y      = 3;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;
  localparam int DEF_STRIDE = 3;

  // LSB of element (r,c) inside a flattened window, r=0 is the oldest line.
  function automatic int elem_lsb(input int depth, input int x, input int r, input int c);
    return depth * (r * x + c);
  endfunction

endpackage

// File: rtl/pool_window_buffer_line_delay.sv
// One image line of delay: read-before-write register array indexed by column.
// Contents are intentionally not reset; stale data is masked by the emit logic.
module pool_window_buffer_line_delay #(
  parameter int DEPTH = 8,
  parameter int IMG_W = 8,
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CW-1:0]    col,
  input  logic [DEPTH-1:0] wr_data,
  output logic [DEPTH-1:0] rd_data
);

  logic [DEPTH-1:0] mem [IMG_W];

  assign rd_data = mem[col];

  always_ff @(posedge clk) begin
    if (we) mem[col] <= wr_data;
  end

endmodule

// File: rtl/pool_window_buffer.sv
// Streaming X-by-Y window generator feeding the Max pooling kernel.
// Buffers Y-1 lines plus a shift window and emits stride-aligned windows.
module pool_window_buffer
  import pool_window_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int X      = DEF_X,
  parameter int Y      = DEF_Y,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEPTH*X*Y-1:0]   out_window,
  output logic                   out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [PW-1:0]      col_ph, row_ph;
  logic               acc, col_end, row_end, emit;
  logic [DEPTH-1:0]   tap     [Y-1];
  logic [DEPTH-1:0]   new_col [Y];
  logic [DEPTH-1:0]   win     [Y][X];
  logic [DEPTH-1:0]   nxt     [Y][X];
  logic [DEPTH*X*Y-1:0] shifted;

  function automatic logic [PW-1:0] ph_inc(input logic [PW-1:0] p);
    return (p == PW'(STRIDE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign emit     = (int'(col) >= X - 1) && (int'(row) >= Y - 1) &&
                    (col_ph == '0) && (row_ph == '0);

  // line[k] carries pixels k+1 lines old, so it feeds window row Y-2-k.
  for (genvar k = 0; k < Y - 1; k++) begin : g_line
    if (k == 0) begin : g_first
      pool_window_buffer_line_delay #(.DEPTH(DEPTH), .IMG_W(IMG_W)) u_line (
        .clk(clk), .we(acc), .col(col), .wr_data(in_pixel), .rd_data(tap[k])
      );
    end else begin : g_chain
      pool_window_buffer_line_delay #(.DEPTH(DEPTH), .IMG_W(IMG_W)) u_line (
        .clk(clk), .we(acc), .col(col), .wr_data(tap[k-1]), .rd_data(tap[k])
      );
    end
    assign new_col[Y-2-k] = tap[k];
  end
  assign new_col[Y-1] = in_pixel;

  always_comb begin
    shifted = '0;
    for (int r = 0; r < Y; r++) begin
      for (int c = 0; c < X - 1; c++) nxt[r][c] = win[r][c+1];
      nxt[r][X-1] = new_col[r];
      for (int c = 0; c < X; c++) shifted[elem_lsb(DEPTH, X, r, c) +: DEPTH] = nxt[r][c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
      for (int r = 0; r < Y; r++)
        for (int c = 0; c < X; c++) win[r][c] <= '0;
    end else if (acc) begin
      win <= nxt;
      if (col_end) begin
        col    <= '0;
        col_ph <= '0;
        if (row_end) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + 1'b1;
          if (int'(row) >= Y - 1) row_ph <= ph_inc(row_ph);
        end
      end else begin
        col <= col + 1'b1;
        if (int'(col) >= X - 1) col_ph <= ph_inc(col_ph);
      end
    end
  end

  // A new emit wins over retiring the held window in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_window <= '0;
    end else if (acc && emit) begin
      out_valid  <= 1'b1;
      out_last   <= col_end && row_end;
      out_window <= shifted;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench: 2x2 stride-2 and stride-1 on a 4x4 image, plus the default
// 3x3 stride-3 8x8 configuration with stall, back-to-back and mid-frame reset.
module tb_pool_window_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ab_valid = 1'b0;
  logic [7:0]  ab_pixel = '0;
  logic        ab_ready = 1'b1;
  logic        a_in_ready, a_out_valid, a_out_last;
  logic [31:0] a_window;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [31:0] b_window;

  logic        c_valid = 1'b0;
  logic [7:0]  c_pixel = '0;
  logic        c_out_ready = 1'b1;
  logic        c_in_ready, c_out_valid, c_out_last;
  logic [71:0] c_window;

  pool_window_buffer #(.DEPTH(8), .X(2), .Y(2), .IMG_W(4), .IMG_H(4), .STRIDE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(ab_valid), .in_ready(a_in_ready), .in_pixel(ab_pixel),
    .out_valid(a_out_valid), .out_ready(ab_ready), .out_window(a_window), .out_last(a_out_last)
  );

  pool_window_buffer #(.DEPTH(8), .X(2), .Y(2), .IMG_W(4), .IMG_H(4), .STRIDE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(ab_valid), .in_ready(b_in_ready), .in_pixel(ab_pixel),
    .out_valid(b_out_valid), .out_ready(ab_ready), .out_window(b_window), .out_last(b_out_last)
  );

  pool_window_buffer u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_in_ready), .in_pixel(c_pixel),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_window(c_window), .out_last(c_out_last)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] qa_win[$];
  logic        qa_last[$];
  int          qa_idx[$];
  logic [31:0] qb_win[$];
  logic        qb_last[$];
  logic [71:0] qc_win[$];
  logic        qc_last[$];
  int          qc_idx[$];
  int a_cnt = 0;
  int c_cnt = 0;

  logic [31:0] exp_a [4];
  logic [31:0] exp_b [9];
  logic [71:0] exp_c [4];
  int          idx_a [4];
  int          idx_c [4];

  // Record each window on its handshake, tagged with the last accepted pixel index.
  always @(negedge clk) begin
    if (a_out_valid && ab_ready) begin
      qa_win.push_back(a_window); qa_last.push_back(a_out_last); qa_idx.push_back(a_cnt - 1);
    end
    if (b_out_valid && ab_ready) begin
      qb_win.push_back(b_window); qb_last.push_back(b_out_last);
    end
    if (c_out_valid && c_out_ready) begin
      qc_win.push_back(c_window); qc_last.push_back(c_out_last); qc_idx.push_back(c_cnt - 1);
    end
    if (ab_valid && a_in_ready) a_cnt++;
    if (c_valid && c_in_ready) c_cnt++;
  end

  task automatic clear_all();
    qa_win.delete(); qa_last.delete(); qa_idx.delete();
    qb_win.delete(); qb_last.delete();
    qc_win.delete(); qc_last.delete(); qc_idx.delete();
    a_cnt = 0; c_cnt = 0;
  endtask

  task automatic feed_ab(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      ab_valid = 1'b1;
      ab_pixel = 8'(i % 16);
      w = 0;
      @(negedge clk);
      while (!(a_in_ready && b_in_ready) && w < 200) begin @(negedge clk); w++; end
      if (!(a_in_ready && b_in_ready)) begin
        total++; bad++;
        $display("FAIL feed_ab_timeout: pixel %0d not accepted within 200 cycles", i);
        break;
      end
      @(posedge clk); #1;
    end
    ab_valid = 1'b0;
    ab_pixel = '0;
  endtask

  task automatic feed_c(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      c_valid = 1'b1;
      c_pixel = 8'(i);
      w = 0;
      @(negedge clk);
      while (!c_in_ready && w < 200) begin @(negedge clk); w++; end
      if (!c_in_ready) begin
        total++; bad++;
        $display("FAIL feed_c_timeout: pixel %0d not accepted within 200 cycles", i);
        break;
      end
      @(posedge clk); #1;
    end
    c_valid = 1'b0;
    c_pixel = '0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_c_frame(input string tag, input bit check_idx);
    total++;
    if (qc_win.size() !== 4) begin
      bad++; $display("FAIL %s_count: got %0d windows, want 4", tag, qc_win.size());
    end
    for (int i = 0; i < 4 && i < qc_win.size(); i++) begin
      total++;
      if (qc_win[i] !== exp_c[i]) begin
        bad++; $display("FAIL %s_win%0d: got %h want %h", tag, i, qc_win[i], exp_c[i]);
      end
      total++;
      if (qc_last[i] !== 1'b0) begin
        bad++; $display("FAIL %s_last%0d: got %b want 0", tag, i, qc_last[i]);
      end
      if (check_idx) begin
        total++;
        if (qc_idx[i] !== idx_c[i]) begin
          bad++; $display("FAIL %s_idx%0d: got %0d want %0d", tag, i, qc_idx[i], idx_c[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_a_in_ready: got %b want 1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_a_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_out_last !== 1'b0) begin bad++; $display("FAIL rst_a_out_last: got %b want 0", a_out_last); end
    total++; if (a_window !== 32'h0) begin bad++; $display("FAIL rst_a_window: got %h want 0", a_window); end
    total++; if (c_in_ready !== 1'b1) begin bad++; $display("FAIL rst_c_in_ready: got %b want 1", c_in_ready); end
    total++; if (c_out_valid !== 1'b0) begin bad++; $display("FAIL rst_c_out_valid: got %b want 0", c_out_valid); end
    total++; if (c_window !== 72'h0) begin bad++; $display("FAIL rst_c_window: got %h want 0", c_window); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_small_stride();
    logic [31:0] w;
    int m;
    clear_all();
    feed_ab(16);
    drain();
    total++;
    if (qa_win.size() !== 4) begin bad++; $display("FAIL s2_count: got %0d want 4", qa_win.size()); end
    for (int i = 0; i < 4 && i < qa_win.size(); i++) begin
      w = qa_win[i];
      total++;
      if (w !== exp_a[i]) begin bad++; $display("FAIL s2_win%0d: got %h want %h", i, w, exp_a[i]); end
      total++;
      if (qa_last[i] !== (i == 3)) begin bad++; $display("FAIL s2_last%0d: got %b want %b", i, qa_last[i], i == 3); end
      total++;
      if (qa_idx[i] !== idx_a[i]) begin bad++; $display("FAIL s2_idx%0d: got %0d want %0d", i, qa_idx[i], idx_a[i]); end
      m = 0;
      for (int k = 0; k < 4; k++) if (int'(w[8*k +: 8]) > m) m = int'(w[8*k +: 8]);
      total++;
      if (m !== idx_a[i]) begin bad++; $display("FAIL s2_max%0d: got %0d want %0d", i, m, idx_a[i]); end
    end
    total++;
    if (qb_win.size() !== 9) begin bad++; $display("FAIL s1_count: got %0d want 9", qb_win.size()); end
    for (int i = 0; i < 9 && i < qb_win.size(); i++) begin
      total++;
      if (qb_win[i] !== exp_b[i]) begin bad++; $display("FAIL s1_win%0d: got %h want %h", i, qb_win[i], exp_b[i]); end
      total++;
      if (qb_last[i] !== (i == 8)) begin bad++; $display("FAIL s1_last%0d: got %b want %b", i, qb_last[i], i == 8); end
    end
  endtask

  task automatic test_default_stride();
    logic [71:0] w;
    int m;
    clear_all();
    c_out_ready = 1'b1;
    feed_c(64);
    drain();
    check_c_frame("def", 1'b1);
    if (qc_win.size() > 0) begin
      w = qc_win[0];
      m = 0;
      for (int k = 0; k < 9; k++) if (int'(w[8*k +: 8]) > m) m = int'(w[8*k +: 8]);
      total++;
      if (m !== 18) begin bad++; $display("FAIL def_max0: got %0d want 18", m); end
    end
  endtask

  task automatic test_stall();
    clear_all();
    c_out_ready = 1'b0;
    fork
      feed_c(64);
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!c_out_valid && w < 200) begin @(negedge clk); w++; end
        total++;
        if (!c_out_valid) begin
          bad++; $display("FAIL stall_first_valid: got %b want 1 within 200 cycles", c_out_valid);
        end
        for (int i = 0; i < 10; i++) begin
          total++;
          if (c_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready%0d: got %b want 0", i, c_in_ready); end
          total++;
          if (c_window !== exp_c[0]) begin bad++; $display("FAIL stall_window%0d: got %h want %h", i, c_window, exp_c[0]); end
          @(negedge clk);
        end
        @(posedge clk); #1;
        c_out_ready = 1'b1;
      end
    join
    drain();
    check_c_frame("stall", 1'b0);
  endtask

  task automatic test_back_to_back();
    int lasts;
    clear_all();
    feed_ab(32);
    drain();
    total++;
    if (qa_win.size() !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", qa_win.size()); end
    lasts = 0;
    for (int i = 0; i < 8 && i < qa_win.size(); i++) begin
      total++;
      if (qa_win[i] !== exp_a[i % 4]) begin bad++; $display("FAIL b2b_win%0d: got %h want %h", i, qa_win[i], exp_a[i % 4]); end
      total++;
      if (qa_last[i] !== (i % 4 == 3)) begin bad++; $display("FAIL b2b_last%0d: got %b want %b", i, qa_last[i], i % 4 == 3); end
      if (qa_last[i]) lasts++;
    end
    total++;
    if (lasts !== 2) begin bad++; $display("FAIL b2b_last_count: got %0d want 2", lasts); end
  endtask

  task automatic test_reset_mid_frame();
    clear_all();
    c_out_ready = 1'b1;
    feed_c(8);
    total++;
    if (qc_win.size() !== 0) begin bad++; $display("FAIL midrst_pre_windows: got %0d want 0", qc_win.size()); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (c_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", c_out_valid); end
    @(posedge clk); #1;
    clear_all();
    feed_c(64);
    drain();
    check_c_frame("midrst", 1'b1);
  endtask

  initial begin
    exp_a = '{32'h05040100, 32'h07060302, 32'h0D0C0908, 32'h0F0E0B0A};
    idx_a = '{5, 7, 13, 15};
    exp_b = '{32'h05040100, 32'h06050201, 32'h07060302,
              32'h09080504, 32'h0A090605, 32'h0B0A0706,
              32'h0D0C0908, 32'h0E0D0A09, 32'h0F0E0B0A};
    exp_c = '{72'h121110_0A0908_020100, 72'h151413_0D0C0B_050403,
              72'h2A2928_222120_1A1918, 72'h2D2C2B_252423_1D1C1B};
    idx_c = '{18, 21, 42, 45};

    test_reset();
    test_small_stride();
    test_default_stride();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
